fphub_mult: RTL and testbench



---
 rtl/fphub_pkg.sv | 17 +
 rtl/fphub_norm_round.sv | 31 +++
 rtl/fphub_mult.sv | 77 +++++++
 tb/tb_fphub_mult.sv | 116 +++++++++++
 4 files changed

// File: rtl/fphub_pkg.sv
// fphub_pkg: shared HUB float constants, operand type and exponent helpers
package fphub_pkg;
  localparam int M_DEF = 23;
  localparam int E_DEF = 8;
  typedef struct packed {
    logic             sign;
    logic [E_DEF-1:0] exp;
    logic [M_DEF-1:0] frac;
  } fphub_t;
  localparam logic [E_DEF-1:0] EXP_ZERO = '0;
  function automatic int bias(input int e);
    return (1 << (e - 1)) - 1;
  endfunction
  function automatic int exp_inf(input int e);
    return (1 << e) - 1;
  endfunction
endpackage

// File: rtl/fphub_norm_round.sv
// fphub_norm_round: normalise, HUB-truncate, range check and special override
module fphub_norm_round
  import fphub_pkg::*;
#(
  parameter int M = 23,
  parameter int E = 8
) (
  input  logic         s,
  input  logic         zero,
  input  logic         inf,
  input  logic [M+1:0] p,
  input  logic [E+1:0] e,
  output logic [E+M:0] z
);
  logic         n;
  logic [M-1:0] f;
  logic [E+1:0] en;
  logic         ovf;
  logic         unf;
  always_comb begin
    n   = p[M+1];
    f   = n ? p[M:1] : p[M-1:0];
    en  = e + (E+2)'(n);
    ovf = !en[E+1] && en[E:0] >= (E+1)'(exp_inf(E));
    unf = en[E+1] || en == '0;
    z   = zero ? {s, {(E+M){1'b0}}} :
          (inf || ovf) ? {s, {E{1'b1}}, {M{1'b0}}} :
          unf ? {s, {(E+M){1'b0}}} :
          {s, en[E-1:0], f};
  end
endmodule

// File: rtl/fphub_mult.sv
// fphub_mult: pipelined HUB floating-point multiplier; FPHUB_MULT_PIPE_EN adds a second stage
module fphub_mult
  import fphub_pkg::*;
#(
  parameter int M = 23,
  parameter int E = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [E+M:0] x,
  input  logic [E+M:0] y,
  output logic         out_valid,
  output logic [E+M:0] z
);
  localparam int PW = 2 * M + 4;
  localparam logic [E+1:0] BIAS = (E+2)'(bias(E));
  logic [E-1:0] ex, ey;
  logic         s0, zero0, inf0;
  logic [M+1:0] p0;
  logic [E+1:0] e0;
  logic         v1, s1, zero1, inf1;
  logic [M+1:0] p1;
  logic [E+1:0] e1;
  logic [E+M:0] zn;
  assign ex    = x[E+M-1:M];
  assign ey    = y[E+M-1:M];
  assign s0    = x[E+M] ^ y[E+M];
  assign zero0 = ex == EXP_ZERO[E-1:0] || ey == EXP_ZERO[E-1:0];
  assign inf0  = &ex || &ey;
  // only the leading M+2 product bits survive HUB truncation
  assign p0    = (M+2)'((PW'({1'b1, x[M-1:0], 1'b1}) * PW'({1'b1, y[M-1:0], 1'b1})) >> (M + 2));
  assign e0    = {2'b00, ex} + {2'b00, ey} - BIAS;
`ifdef FPHUB_MULT_PIPE_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1    <= 1'b0;
      s1    <= 1'b0;
      zero1 <= 1'b0;
      inf1  <= 1'b0;
      p1    <= '0;
      e1    <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        s1    <= s0;
        zero1 <= zero0;
        inf1  <= inf0;
        p1    <= p0;
        e1    <= e0;
      end
    end
`else
  assign v1    = in_valid;
  assign s1    = s0;
  assign zero1 = zero0;
  assign inf1  = inf0;
  assign p1    = p0;
  assign e1    = e0;
`endif
  fphub_norm_round #(.M(M), .E(E)) u_nr (
    .s   (s1),
    .zero(zero1),
    .inf (inf1),
    .p   (p1),
    .e   (e1),
    .z   (zn)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      z         <= '0;
    end else begin
      out_valid <= v1;
      if (v1) z <= zn;
    end
endmodule

// File: tb/tb_fphub_mult.sv
// tb_fphub_mult: directed checks of the HUB multiplier, latency-aware for FPHUB_MULT_PIPE_EN
module tb_fphub_mult;
`ifdef FPHUB_MULT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        out_valid;
  logic [31:0] z;
  int checks = 0;
  int errors = 0;

  fphub_mult #(.M(23), .E(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .x        (x),
    .y        (y),
    .out_valid(out_valid),
    .z        (z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e);
    @(negedge clk);
    x = a;
    y = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
`ifdef FPHUB_MULT_PIPE_EN
    check({tag, "_early"}, {31'b0, out_valid}, 32'd0);
    @(negedge clk);
`endif
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check(tag, z, e);
    @(negedge clk);
    check({tag, "_drop"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_hold"}, z, e);
  endtask

  logic [31:0] sa[4] = '{32'h40000000, 32'h3FC00000, 32'hC0000000, 32'h7F000000};
  logic [31:0] sb[4] = '{32'h40400000, 32'h3FC00000, 32'h40400000, 32'h7F000000};
  logic [31:0] se[4] = '{32'h40C00001, 32'h40100000, 32'hC0C00001, 32'h7F800000};

  initial begin
    #1;
    check("reset_z", z, 32'h0);
    check("reset_valid", {31'b0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op("two_x_three", 32'h40000000, 32'h40400000, 32'h40C00001);
    run_op("norm_shift", 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    run_op("one_x_one", 32'h3F800000, 32'h3F800000, 32'h3F800001);
    run_op("neg_sign", 32'hC0000000, 32'h40400000, 32'hC0C00001);
    run_op("neg_zero", 32'h80000000, 32'h40400000, 32'h80000000);
    run_op("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000);
    run_op("underflow", 32'h00800000, 32'h00800000, 32'h00000000);
    run_op("inf_x_two", 32'h7F800000, 32'h40000000, 32'h7F800000);
    run_op("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h00000000);
    run_op("inf_x_negzero", 32'h7F800000, 32'h80000000, 32'h80000000);
    // back-to-back stream: one result per cycle, in order
    for (int i = 0; i < 4 + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) begin
        check($sformatf("stream%0d_valid", i - LAT), {31'b0, out_valid}, 32'd1);
        check($sformatf("stream%0d", i - LAT), z, se[i-LAT]);
      end
      if (i < 4) begin
        x = sa[i];
        y = sb[i];
        in_valid = 1'b1;
      end else in_valid = 1'b0;
    end
    @(negedge clk);
    check("stream_end_valid", {31'b0, out_valid}, 32'd0);
    // reset asserted asynchronously with operations in flight
    x = 32'h40000000;
    y = 32'h40400000;
    in_valid = 1'b1;
    @(negedge clk);
    x = 32'h3FC00000;
    y = 32'h3FC00000;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_z", z, 32'h0);
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_held_z", z, 32'h0);
    check("rst_held_valid", {31'b0, out_valid}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_quiet%0d", i), {31'b0, out_valid}, 32'd0);
    end
    run_op("post_rst_op", 32'hC0000000, 32'h40400000, 32'hC0C00001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
